// File: rtl/demod_pkg.sv
// demod_pkg: shared definitions for the symbol demodulator.
//   state_t     - reassembly FSM states
//   NIB_MSB     - top bit of the data nibble inside a symbol
//   PAR_BIT     - position of the odd-parity bit inside a symbol
//   DEF_TIMEOUT - default idle limit between high and low symbol
package demod_pkg;

  typedef enum logic {
    WAIT_HI = 1'b0,
    WAIT_LO = 1'b1
  } state_t;

  localparam int NIB_MSB     = 3;
  localparam int PAR_BIT     = 4;
  localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/demod_out_buf.sv
// demod_out_buf: write-side buffer between the byte reassembler and the
// receive FIFO. Holds one pending byte while the FIFO is full.
//   clk, rst_n      - clock, async active-low reset
//   byte_in[7:0]    - completed byte
//   byte_vld        - byte_in completes this cycle
//   full            - downstream full; blocks writes
//   data_out[7:0]   - registered write data
//   wr              - one-cycle write strobe
//   ovf             - sticky: a byte was dropped because pending was occupied
module demod_out_buf
  import demod_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       byte_vld,
  input  logic       full,
  output logic [7:0] data_out,
  output logic       wr,
  output logic       ovf
);

  logic [7:0] pend;
  logic       pend_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      wr       <= 1'b0;
      ovf      <= 1'b0;
      pend     <= '0;
      pend_vld <= 1'b0;
    end else begin
      wr <= 1'b0;
      if (pend_vld) begin
        if (!full) begin
          // pending goes out first; a byte completing now refills the slot
          data_out <= pend;
          wr       <= 1'b1;
          if (byte_vld) pend <= byte_in;
          else          pend_vld <= 1'b0;
        end else if (byte_vld) begin
          ovf <= 1'b1;
        end
      end else if (byte_vld) begin
        if (!full) begin
          data_out <= byte_in;
          wr       <= 1'b1;
        end else begin
          pend     <= byte_in;
          pend_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/demod.sv
// demod: receive-side symbol demodulator. Checks odd parity on each 5-bit
// symbol, pairs nibbles (high first) into bytes and hands them to the
// output buffer.
//   clk, rst_n     - clock, async active-low reset
//   mod_en         - symbol valid strobe
//   dmod[4:0]      - [3:0] nibble, [4] odd-parity bit
//   full           - downstream buffer full
//   data_out[7:0]  - reassembled byte
//   wr             - write strobe
//   par_err        - one-cycle pulse after a bad-parity symbol
//   ovf            - sticky overflow
//   err_cnt        - saturating count of parity errors and timeouts
//
// state   | meaning
// WAIT_HI | expecting the high nibble symbol
// WAIT_LO | high nibble held; expecting low nibble, idle cycles counted
module demod
  import demod_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int ERR_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mod_en,
  input  logic [4:0]       dmod,
  input  logic             full,
  output logic [7:0]       data_out,
  output logic             wr,
  output logic             par_err,
  output logic             ovf,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state;
  logic [3:0]      hi;
  logic [TO_W-1:0] to_cnt;

  logic good;
  logic timeout;
  logic err_inc;
  logic byte_vld;

  assign good     = dmod[PAR_BIT] ^ (^dmod[NIB_MSB:0]);
  // idle cycles only advance the timer, so a symbol always beats a timeout
  assign timeout  = (state == WAIT_LO) && !mod_en && (to_cnt == TO_LAST);
  assign err_inc  = (mod_en && !good) || timeout;
  assign byte_vld = (state == WAIT_LO) && mod_en && good;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= WAIT_HI;
      hi      <= '0;
      to_cnt  <= '0;
      par_err <= 1'b0;
      err_cnt <= '0;
    end else begin
      par_err <= mod_en && !good;
      if (err_inc && (err_cnt != {ERR_W{1'b1}}))
        err_cnt <= err_cnt + ERR_W'(1);
      case (state)
        WAIT_HI: begin
          if (mod_en && good) begin
            hi     <= dmod[NIB_MSB:0];
            to_cnt <= '0;
            state  <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (mod_en) begin
            // good or bad, the pair is finished; bad drops the high nibble
            state  <= WAIT_HI;
            to_cnt <= '0;
          end else if (timeout) begin
            state  <= WAIT_HI;
            to_cnt <= '0;
            hi     <= '0;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= WAIT_HI;
      endcase
    end
  end

  demod_out_buf u_out_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .byte_in  ({hi, dmod[NIB_MSB:0]}),
    .byte_vld (byte_vld),
    .full     (full),
    .data_out (data_out),
    .wr       (wr),
    .ovf      (ovf)
  );

endmodule

// File: tb/tb_demod.sv
module tb_demod;

  logic       clk;
  logic       rst_n;
  logic       mod_en;
  logic [4:0] dmod;
  logic       full;
  logic [7:0] data_out;
  logic       wr;
  logic       par_err;
  logic       ovf;
  logic [7:0] err_cnt;

  int n_tests;
  int n_fail;
  int cyc_n;

  typedef struct {
    logic [7:0] d;
    int         due;   // cycle where wr must be seen, -1 = any time
  } exp_t;
  exp_t sb[$];

  demod #(.TIMEOUT(16), .ERR_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mod_en   (mod_en),
    .dmod     (dmod),
    .full     (full),
    .data_out (data_out),
    .wr       (wr),
    .par_err  (par_err),
    .ovf      (ovf),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  function automatic logic [4:0] good_sym(input logic [3:0] nib);
    return {~(^nib), nib};
  endfunction

  function automatic logic [4:0] bad_sym(input logic [3:0] nib);
    return {^nib, nib};
  endfunction

  // inputs change on the falling edge; outputs only move on the rising edge
  task automatic drive(input logic en, input logic [4:0] sym, input logic f);
    @(negedge clk);
    mod_en = en;
    dmod   = sym;
    full   = f;
  endtask

  task automatic idle(input int n, input logic f);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, f);
  endtask

  // push: 0 = none, 1 = exact latency, 2 = deferred by backpressure
  task automatic send_byte(input logic [7:0] b, input logic f, input int push);
    exp_t e;
    drive(1'b1, good_sym(b[7:4]), f);
    drive(1'b1, good_sym(b[3:0]), f);
    e.d   = b;
    e.due = (push == 1) ? cyc_n + 1 : -1;
    if (push != 0) sb.push_back(e);
  endtask

  // scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && wr) begin
        if (sb.size() == 0) begin
          chk("unexpected_wr", {24'd0, data_out}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("wr_data", {24'd0, data_out}, {24'd0, e.d});
          if (e.due >= 0) chk("wr_latency", cyc_n, e.due);
        end
      end
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc_n   = 0;
    rst_n   = 1'b0;
    mod_en  = 1'b0;
    dmod    = 5'd0;
    full    = 1'b0;
    #12;
    chk("rst_data_out", {24'd0, data_out}, 0);
    chk("rst_wr", {31'd0, wr}, 0);
    chk("rst_par_err", {31'd0, par_err}, 0);
    chk("rst_ovf", {31'd0, ovf}, 0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back bytes, one symbol per cycle
    send_byte(8'h11, 1'b0, 1);
    send_byte(8'h12, 1'b0, 1);
    idle(3, 1'b0);
    chk("t1_err_cnt", {24'd0, err_cnt}, 0);

    // parity error in WAIT_LO drops the high nibble
    drive(1'b1, good_sym(4'h5), 1'b0);
    drive(1'b1, 5'b00011, 1'b0);
    drive(1'b0, 5'd0, 1'b0);
    chk("t2_par_err", {31'd0, par_err}, 1);
    chk("t2_err_cnt", {24'd0, err_cnt}, 1);
    drive(1'b0, 5'd0, 1'b0);
    chk("t2_par_err_pulse", {31'd0, par_err}, 0);
    send_byte(8'hA3, 1'b0, 1);
    idle(2, 1'b0);

    // timeout: 15 idle cycles is still fine, the 16th resyncs
    drive(1'b1, good_sym(4'h7), 1'b0);
    idle(16, 1'b0);
    chk("t3_err_cnt_15", {24'd0, err_cnt}, 1);
    drive(1'b0, 5'd0, 1'b0);
    chk("t3_err_cnt_16", {24'd0, err_cnt}, 2);
    send_byte(8'h12, 1'b0, 1);
    idle(2, 1'b0);

    // symbol on the cycle the timer would expire wins
    drive(1'b1, good_sym(4'h6), 1'b0);
    idle(15, 1'b0);
    drive(1'b1, good_sym(4'h9), 1'b0);
    sb.push_back('{d: 8'h69, due: cyc_n + 1});
    idle(2, 1'b0);
    chk("t3b_err_cnt", {24'd0, err_cnt}, 2);

    // single byte held by backpressure
    send_byte(8'h3C, 1'b1, 2);
    idle(4, 1'b1);
    idle(3, 1'b0);
    chk("t4_sb_drained", sb.size(), 0);
    chk("t4_ovf", {31'd0, ovf}, 0);

    // pending emission coincides with a new byte completing
    send_byte(8'h21, 1'b1, 2);
    drive(1'b1, good_sym(4'h4), 1'b1);
    drive(1'b1, good_sym(4'h2), 1'b0);
    sb.push_back('{d: 8'h42, due: -1});
    idle(4, 1'b0);
    chk("t4b_sb_drained", sb.size(), 0);
    chk("t4b_ovf", {31'd0, ovf}, 0);

    // overflow: second byte dropped, pending kept, ovf sticky
    send_byte(8'h3C, 1'b1, 2);
    send_byte(8'h4D, 1'b1, 0);
    idle(2, 1'b1);
    chk("t5_ovf", {31'd0, ovf}, 1);
    idle(4, 1'b0);
    chk("t5_sb_drained", sb.size(), 0);
    chk("t5_ovf_sticky", {31'd0, ovf}, 1);

    // reset mid-byte with a pending byte present
    send_byte(8'h55, 1'b1, 0);
    drive(1'b1, good_sym(4'h6), 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_data_out", {24'd0, data_out}, 0);
    chk("t6_wr", {31'd0, wr}, 0);
    chk("t6_ovf", {31'd0, ovf}, 0);
    chk("t6_err_cnt", {24'd0, err_cnt}, 0);
    chk("t6_par_err", {31'd0, par_err}, 0);
    idle(2, 1'b0);
    rst_n = 1'b1;
    idle(6, 1'b0);
    chk("t6_no_wr_after", sb.size(), 0);

    // error counter saturation
    for (int i = 0; i < 300; i++) drive(1'b1, bad_sym(4'(i)), 1'b0);
    drive(1'b0, 5'd0, 1'b0);
    chk("t7_err_sat", {24'd0, err_cnt}, 255);
    chk("t7_par_err_last", {31'd0, par_err}, 1);
    idle(2, 1'b0);

    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
